// File: rtl/vdmem_multibeat.sv
// Scalar/vector data memory behind a PORT_LANES-wide row port; vector ops take
// LANES/PORT_LANES beats, one row per cycle, with a single response at the end.
module vdmem_multibeat #(
  parameter int ELEM_W     = 16,
  parameter int LANES      = 16,
  parameter int PORT_LANES = 4,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic                    src_sel,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [ELEM_W-1:0]       w_data_a,
  input  logic [LANES*ELEM_W-1:0] w_data_b,
  input  logic [LANES-1:0]        w_mask,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [ELEM_W-1:0]       q_a,
  output logic [LANES*ELEM_W-1:0] q_b
);

  localparam int BEATS  = LANES / PORT_LANES;
  localparam int ROWS   = DEPTH / PORT_LANES;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SLOT_W = (PORT_LANES > 1) ? $clog2(PORT_LANES) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] VEC_MAX = ADDR_W'(DEPTH - LANES);

  typedef logic [PORT_LANES-1:0][ELEM_W-1:0] row_t;
  typedef enum logic {IDLE, BUSY} state_t;

  state_t                         state_q, state_d;
  logic [BEAT_W-1:0]              beat_q, beat_d;
  logic [ROW_W-1:0]               base_q, base_d;
  logic                           we_q, we_d;
  row_t [BEATS-1:0]               data_q, data_d, rdbuf_q, rdbuf_d, wb_rows;
  logic [BEATS-1:0][PORT_LANES-1:0] mask_q, mask_d, wm_rows;
  logic [ELEM_W-1:0]              q_a_q, q_a_d;
  logic [LANES*ELEM_W-1:0]        q_b_q, q_b_d;
  logic                           rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;

  row_t                           mem_q [ROWS];

  logic                           accept, req_err;
  logic [ROW_W-1:0]               row0;
  logic [SLOT_W-1:0]              slot;
  logic                           acc_en, acc_we, vec_go, last;
  logic [ROW_W-1:0]               acc_row;
  row_t                           acc_wdata, rd_row;
  logic [PORT_LANES-1:0]          acc_wmask;
  logic [BEAT_W-1:0]              vec_beat;

  assign wb_rows   = w_data_b;
  assign wm_rows   = w_mask;
  assign accept    = req_valid && (state_q == IDLE);
  assign row0      = ROW_W'(addr / ADDR_W'(PORT_LANES));
  assign slot      = SLOT_W'(addr % ADDR_W'(PORT_LANES));
  assign rd_row    = mem_q[acc_row];
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign q_a       = q_a_q;
  assign q_b       = q_b_q;

  always_comb begin
    if (src_sel) req_err = ((addr % ADDR_W'(LANES)) != '0) || (addr > VEC_MAX);
    else         req_err = (addr >= DEPTH_A);
  end

  // Row port: beat 0 is driven from live inputs, later beats from the captured request.
  always_comb begin
    acc_en    = 1'b0;
    acc_we    = 1'b0;
    acc_row   = '0;
    acc_wdata = '0;
    acc_wmask = '0;
    vec_go    = 1'b0;
    vec_beat  = '0;
    last      = 1'b0;
    if (state_q == IDLE) begin
      if (accept && !req_err) begin
        acc_en  = 1'b1;
        acc_we  = req_we;
        acc_row = row0;
        if (src_sel) begin
          acc_wdata = wb_rows[0];
          acc_wmask = wm_rows[0];
          vec_go    = 1'b1;
          last      = (BEATS == 1);
        end else begin
          acc_wdata = {PORT_LANES{w_data_a}};
          acc_wmask = PORT_LANES'(1) << slot;
        end
      end
    end else begin
      acc_en    = 1'b1;
      acc_we    = we_q;
      acc_row   = base_q + ROW_W'(beat_q);
      acc_wdata = data_q[beat_q];
      acc_wmask = mask_q[beat_q];
      vec_go    = 1'b1;
      vec_beat  = beat_q;
      last      = (beat_q == BEAT_W'(BEATS - 1));
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    base_d      = base_q;
    we_d        = we_q;
    data_d      = data_q;
    mask_d      = mask_q;
    rdbuf_d     = rdbuf_q;
    q_a_d       = q_a_q;
    q_b_d       = q_b_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    if (accept) begin
      if (req_err) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end else if (!src_sel) begin
        rsp_valid_d = 1'b1;
        if (!req_we) q_a_d = rd_row[slot];
      end else begin
        base_d = row0;
        we_d   = req_we;
        data_d = wb_rows;
        mask_d = wm_rows;
      end
    end
    // Read beats collect in rdbuf so q_b only ever shows a complete vector.
    if (vec_go) begin
      if (!acc_we) rdbuf_d[vec_beat] = rd_row;
      if (last) begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
        beat_d      = '0;
        if (!acc_we) q_b_d = rdbuf_d;
      end else begin
        state_d = BUSY;
        beat_d  = vec_beat + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      base_q      <= '0;
      we_q        <= 1'b0;
      data_q      <= '0;
      mask_q      <= '0;
      rdbuf_q     <= '0;
      q_a_q       <= '0;
      q_b_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      we_q        <= we_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      rdbuf_q     <= rdbuf_d;
      q_a_q       <= q_a_d;
      q_b_q       <= q_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is never cleared; reset only blocks the write of the current beat.
  always_ff @(posedge clk) begin
    if (!rst && acc_en && acc_we) begin
      for (int s = 0; s < PORT_LANES; s++) begin
        if (acc_wmask[s]) mem_q[acc_row][s] <= acc_wdata[s];
      end
    end
  end

endmodule

// File: tb/tb_vdmem_multibeat.sv
// Directed bench for vdmem_multibeat: element-level memory model plus a timed
// response queue, checked every cycle, with literal spot checks on key results.
module tb_vdmem_multibeat;
  localparam int EW = 16, LN = 16, PL = 4, DP = 1024, AW = 32, BT = LN / PL;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, src_sel = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [EW-1:0] w_data_a = '0;
  logic [LN*EW-1:0] w_data_b = '0;
  logic [LN-1:0] w_mask = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [EW-1:0] q_a;
  logic [LN*EW-1:0] q_b;

  vdmem_multibeat #(.ELEM_W(EW), .LANES(LN), .PORT_LANES(PL), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .src_sel(src_sel), .addr(addr), .w_data_a(w_data_a), .w_data_b(w_data_b), .w_mask(w_mask),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .q_a(q_a), .q_b(q_b));

  always #5 clk = ~clk;

  typedef struct {
    int due; bit err; bit rd; bit vec;
    logic [EW-1:0] qa; logic [LN*EW-1:0] qb;
  } rsp_t;

  rsp_t exp_q[$];
  logic [EW-1:0] mem_m [DP];
  int cyc = 0, tests = 0, fails = 0, err_seen = 0;
  int ready_from = 0, busy_lo = 0, busy_hi = -1;
  logic [EW-1:0] exp_qa = '0;
  logic [LN*EW-1:0] exp_qb = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [LN*EW-1:0] act, input logic [LN*EW-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin : cmp
    rsp_t r;
    bit ev;
    if (!rst) begin
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("rsp_valid", rsp_valid, ev);
      if (rsp_valid && rsp_err) err_seen++;
      if (ev) begin
        r = exp_q.pop_front();
        chk("rsp_err", rsp_err, r.err);
        if (r.rd && !r.err) begin
          if (r.vec) exp_qb = r.qb;
          else       exp_qa = r.qa;
        end
      end
      chk("q_a", q_a, exp_qa);
      chk("q_b", q_b, exp_qb);
      chk("req_ready", req_ready, !(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LN*EW-1:0] vfill(input logic [EW-1:0] b, input bit inc);
    logic [LN*EW-1:0] v;
    for (int i = 0; i < LN; i++) v[i*EW +: EW] = inc ? b + EW'(i) : b;
    return v;
  endfunction

  // keep < LN models a vector write cut short by reset: only the first keep lanes land.
  task automatic send(input bit we, input bit vec, input int a, input logic [EW-1:0] da,
                      input logic [LN*EW-1:0] db, input logic [LN-1:0] m, input int keep = LN);
    bit err;
    int lat;
    rsp_t r;
    req_valid = 1'b1; req_we = we; src_sel = vec; addr = AW'(a);
    w_data_a = da; w_data_b = db; w_mask = m;
    while (cyc < ready_from) step();
    err = vec ? (((a % LN) != 0) || (a > DP - LN)) : (a < 0 || a >= DP);
    lat = (vec && !err) ? BT : 1;
    ready_from = cyc + lat;
    if (lat > 1) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + lat - 1;
    end
    r.due = cyc + lat; r.err = err; r.rd = !we; r.vec = vec; r.qa = '0; r.qb = '0;
    if (!err) begin
      if (we) begin
        if (!vec) mem_m[a] = da;
        else for (int i = 0; i < LN; i++) if (m[i] && i < keep) mem_m[a+i] = db[i*EW +: EW];
      end else begin
        if (!vec) r.qa = mem_m[a];
        else for (int i = 0; i < LN; i++) r.qb[i*EW +: EW] = mem_m[a+i];
      end
    end
    if (keep == LN) exp_q.push_back(r);
    step();
    req_valid = 1'b0; addr = '1; req_we = ~req_we;
    w_data_a = ~w_data_a; w_data_b = ~w_data_b; w_mask = ~w_mask;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) step();
    if (exp_q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d responses still outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0;
    exp_q.delete(); exp_qa = '0; exp_qb = '0; busy_hi = -1;
    step();
    rst = 1'b0;
    ready_from = cyc;
  endtask

  initial begin
    int base;
    repeat (3) step();
    rst = 1'b0;
    ready_from = cyc;
    chk("reset req_ready", req_ready, 1'b1);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset rsp_err", rsp_err, 1'b0);
    chk("reset q_a", q_a, '0);
    chk("reset q_b", q_b, '0);

    // 1: scalar write then read-after-write
    send(1, 0, 'h10, 16'hFFFF, '0, '0);
    send(0, 0, 'h10, '0, '0, '0);
    drain();
    chk("t1 q_a", q_a, 16'hFFFF);

    // 2: full vector write then read, next request held during BUSY
    send(1, 1, 'h20, '0, vfill(16'hA000, 1), 16'hFFFF);
    send(0, 1, 'h20, '0, '0, '0);
    drain();
    chk("t2 lane0", q_b[0 +: EW], 16'hA000);
    chk("t2 lane15", q_b[15*EW +: EW], 16'hA00F);

    // 3: masked vector write
    send(1, 1, 'h20, '0, vfill(16'h5555, 0), 16'h00FF);
    send(0, 1, 'h20, '0, '0, '0);
    drain();
    chk("t3 lane7", q_b[7*EW +: EW], 16'h5555);
    chk("t3 lane8", q_b[8*EW +: EW], 16'hA008);

    // 4: last legal vector slot, then misaligned / out-of-range rejects
    send(1, 1, 1008, '0, vfill(16'h7000, 1), 16'hFFFF);
    drain();
    base = err_seen;
    send(1, 1, 'h21, '0, vfill(16'hDEAD, 0), 16'hFFFF);
    send(1, 1, 1024, '0, vfill(16'hDEAD, 0), 16'hFFFF);
    send(1, 0, 1024, 16'hBEEF, '0, '0);
    drain();
    chk("t4 err count", err_seen - base, 3);
    send(0, 1, 'h20, '0, '0, '0);
    send(0, 0, 1008, '0, '0, '0);
    send(0, 0, 1023, '0, '0, '0);
    drain();
    chk("t4 lane0", q_b[0 +: EW], 16'h5555);
    chk("t4 lane9", q_b[9*EW +: EW], 16'hA009);
    chk("t4 q_a 1023", q_a, 16'h700F);

    // 5: reset during beat 2 of a vector write
    send(1, 1, 'h40, '0, vfill(16'hB000, 1), 16'hFFFF);
    drain();
    send(1, 1, 'h40, '0, vfill(16'h1111, 0), 16'hFFFF, 8);
    step();
    do_reset();
    chk("t5 rsp_valid", rsp_valid, 1'b0);
    chk("t5 req_ready", req_ready, 1'b1);
    chk("t5 q_b", q_b, '0);
    send(0, 1, 'h40, '0, '0, '0);
    drain();
    chk("t5 lane0", q_b[0 +: EW], 16'h1111);
    chk("t5 lane7", q_b[7*EW +: EW], 16'h1111);
    chk("t5 lane8", q_b[8*EW +: EW], 16'hB008);

    // 6: back-to-back scalar writes and reads
    for (int i = 0; i < 4; i++) send(1, 0, i, 16'h0C00 + EW'(i), '0, '0);
    for (int i = 0; i < 4; i++) send(0, 0, i, '0, '0, '0);
    drain();
    chk("t6 q_a", q_a, 16'h0C03);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
